// File: rtl/branch_pred_unit.sv
// rtl/branch_pred_unit.sv - BTB plus saturating-counter branch predictor with optional gshare indexing
// Optional gshare history indexing is compiled in by defining BPU_GSHARE_EN.
module branch_pred_unit #(
  parameter  int ENTRIES = 64,
  parameter  int TAG_W   = 8,
  parameter  int CNT_W   = 2,
  parameter  int GHR_W   = 6,
  localparam int IDX_W   = $clog2(ENTRIES)
) (
  input  logic             i_clk,
  input  logic             i_rstn,
  input  logic [31:0]      i_if_pc,
  output logic             o_pred_taken,
  output logic             o_pred_hit,
  output logic [31:0]      o_pred_next_pc,
  output logic [IDX_W-1:0] o_pred_idx,
  input  logic             i_upd_vld,
  input  logic [31:0]      i_upd_pc,
  input  logic [IDX_W-1:0] i_upd_idx,
  input  logic             i_upd_uncond,
  input  logic             i_upd_taken,
  input  logic [31:0]      i_upd_target
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_WT  = CNT_W'(1 << (CNT_W - 1));
  localparam logic [CNT_W-1:0] CNT_WNT = CNT_W'((1 << (CNT_W - 1)) - 1);

  logic             r_valid  [ENTRIES];
  logic [TAG_W-1:0] r_tag    [ENTRIES];
  logic [31:0]      r_target [ENTRIES];
  logic [CNT_W-1:0] r_cnt    [ENTRIES];

  logic [IDX_W-1:0] w_ghr_idx;

`ifdef BPU_GSHARE_EN
  logic [GHR_W-1:0] r_ghr;
  logic [GHR_W:0]   w_ghr_shift;

  assign w_ghr_shift = {r_ghr, i_upd_taken};

  always_comb begin
    w_ghr_idx              = '0;
    w_ghr_idx[GHR_W-1:0]   = r_ghr;
  end

  // History tracks resolved conditional outcomes only; jumps do not shift it.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      r_ghr <= '0;
    end else if (i_upd_vld && !i_upd_uncond) begin
      r_ghr <= w_ghr_shift[GHR_W-1:0];
    end
  end
`else
  logic [GHR_W-1:0] w_ghr_unused;
  assign w_ghr_unused = '0;
  assign w_ghr_idx    = '0;
`endif

  logic [IDX_W-1:0] w_lkp_idx;
  logic [TAG_W-1:0] w_lkp_tag;
  logic             w_lkp_hit;
  logic             w_lkp_taken;

  assign w_lkp_idx   = i_if_pc[IDX_W+1:2] ^ w_ghr_idx;
  assign w_lkp_tag   = i_if_pc[IDX_W+2+TAG_W-1:IDX_W+2];
  assign w_lkp_hit   = r_valid[w_lkp_idx] && (r_tag[w_lkp_idx] == w_lkp_tag);
  assign w_lkp_taken = w_lkp_hit && r_cnt[w_lkp_idx][CNT_W-1];

  assign o_pred_idx     = w_lkp_idx;
  assign o_pred_hit     = w_lkp_hit;
  assign o_pred_taken   = w_lkp_taken;
  assign o_pred_next_pc = w_lkp_taken ? r_target[w_lkp_idx] : (i_if_pc + 32'd4);

  logic [TAG_W-1:0] w_upd_tag;
  logic             w_upd_taken;
  logic             w_upd_hit;
  logic             w_upd_we;
  logic [CNT_W-1:0] w_cnt_cur;
  logic [CNT_W-1:0] w_cnt_nxt;

  assign w_upd_tag   = i_upd_pc[IDX_W+2+TAG_W-1:IDX_W+2];
  assign w_upd_taken = i_upd_taken | i_upd_uncond;
  assign w_upd_hit   = r_valid[i_upd_idx] && (r_tag[i_upd_idx] == w_upd_tag);
  assign w_cnt_cur   = r_cnt[i_upd_idx];

  // A not-taken miss leaves the entry alone so a hot alias is not evicted.
  always_comb begin
    w_upd_we  = 1'b0;
    w_cnt_nxt = w_cnt_cur;
    if (w_upd_hit) begin
      w_upd_we = 1'b1;
      if (i_upd_uncond) begin
        w_cnt_nxt = CNT_MAX;
      end else if (w_upd_taken) begin
        w_cnt_nxt = (w_cnt_cur == CNT_MAX) ? w_cnt_cur : (w_cnt_cur + CNT_ONE);
      end else begin
        w_cnt_nxt = (w_cnt_cur == '0) ? w_cnt_cur : (w_cnt_cur - CNT_ONE);
      end
    end else if (w_upd_taken) begin
      w_upd_we  = 1'b1;
      w_cnt_nxt = i_upd_uncond ? CNT_MAX : CNT_WT;
    end
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      for (int i = 0; i < ENTRIES; i++) begin
        r_valid[i]  <= 1'b0;
        r_tag[i]    <= '0;
        r_target[i] <= '0;
        r_cnt[i]    <= CNT_WNT;
      end
    end else if (i_upd_vld && w_upd_we) begin
      r_valid[i_upd_idx] <= 1'b1;
      r_tag[i_upd_idx]   <= w_upd_tag;
      r_cnt[i_upd_idx]   <= w_cnt_nxt;
      if (w_upd_taken) begin
        r_target[i_upd_idx] <= i_upd_target;
      end
    end
  end

  logic w_unused;
  assign w_unused = ^{i_upd_pc[IDX_W+1:0], i_upd_pc[31:IDX_W+2+TAG_W]};

endmodule

// File: doc/branch_pred_unit.md
# branch_pred_unit

Parametrised dynamic branch predictor (BTB + saturating-counter table) for the 5-stage RV32I pipeline, replacing static always-taken/not-taken redirect. Looked up combinationally in IF with the fetch PC to produce a predicted next PC, and trained synchronously by resolved branch/jump outcomes from EX. Optional gshare indexing with a global history register is compiled in by macro.

## Interface
- ENTRIES, 64, table depth; power of two, 4..1024; IDX_W = log2(ENTRIES)
- TAG_W, 8, stored tag width; tag = pc[IDX_W+2+TAG_W-1 : IDX_W+2]
- CNT_W, 2, saturating counter width, 1..4
- GHR_W, 6, global history width, 1..IDX_W; used only with BPU_GSHARE_EN
- i_clk  in  1  clock, rising edge
- i_rstn  in  1  reset, asynchronous, active-low
- i_if_pc  in  32  fetch PC (word aligned)
- o_pred_taken  out  1  predicted taken (hit and taken)
- o_pred_hit  out  1  valid entry with matching tag at lookup index
- o_pred_next_pc  out  32  stored target if o_pred_taken, else i_if_pc+4
- o_pred_idx  out  IDX_W  lookup index; pipeline carries it to EX
- i_upd_vld  in  1  one resolved control-flow instruction this cycle
- i_upd_pc  in  32  PC of resolved instruction
- i_upd_idx  in  IDX_W  o_pred_idx captured when that instruction was fetched
- i_upd_uncond  in  1  1 = JAL/JALR, 0 = conditional branch
- i_upd_taken  in  1  actual outcome (forced 1 when i_upd_uncond)
- i_upd_target  in  32  actual branch/jump target

## Operation
- Entry: valid, tag[TAG_W], target[32], cnt[CNT_W]. Flop array, no SRAM.
- Lookup (combinational): idx = i_if_pc[IDX_W+1:2] (XOR GHR under macro); hit = valid[idx] && tag[idx]==tag(i_if_pc); taken = hit && cnt[idx][CNT_W-1].
- Update on rising edge with i_upd_vld=1, at entry i_upd_idx, tag from i_upd_pc:
  - Hit, conditional: cnt saturating +1 if taken, -1 if not; no wrap past 0 or 2^CNT_W-1. Target overwritten when taken.
  - Hit, unconditional: cnt = all ones; target overwritten.
  - Miss, taken: allocate (replace): valid=1, tag, target; cnt = all ones if uncond, else 2^(CNT_W-1) (weakly taken).
  - Miss, not taken: no change.
- Lookup and update to the same index in the same cycle: lookup returns pre-update contents (no bypass).
- i_upd_vld=0: table and GHR hold.
- Predictor never stalls; update port is single-issue, always accepted.

## Timing
- Lookup latency 0 cycles (same-cycle combinational from i_if_pc).
- Update visible to lookup 1 cycle after the sampling edge.
- Reset (async, any time, including mid-update): all valid=0, cnt=2^(CNT_W-1)-1 (weakly not-taken), targets/tags 0, GHR=0. Outputs during/after reset: o_pred_hit=0, o_pred_taken=0, o_pred_next_pc=i_if_pc+4, o_pred_idx=i_if_pc[IDX_W+1:2].
- Update sampled only on a clock edge with i_rstn=1.

## Configuration
- BPU_GSHARE_EN defined: GHR_W-bit register; lookup idx = i_if_pc[IDX_W+1:2] ^ {zeros, GHR}; on each conditional update GHR <= {GHR[GHR_W-2:0], i_upd_taken}; unconditional updates leave GHR. Update still uses i_upd_idx (non-speculative history).
- Not defined: no GHR flops; idx = i_if_pc[IDX_W+1:2]; GHR_W ignored.

## Test plan
- Reset then lookup pc=0x100 -> hit=0, taken=0, next_pc=0x104.
- Update pc=0x100 idx=0 taken target=0x040 cond; next cycle lookup 0x100 -> hit=1, taken=1 (cnt=2), next_pc=0x040.
- Same entry, 2 not-taken updates -> cnt 2->1->0, taken=0, next_pc=0x104; third not-taken stays 0; 4 taken -> cnt saturates at 3.
- Aliasing: after 0x100 allocated, lookup 0x100+4*ENTRIES (same idx, different tag) -> hit=0; taken update there replaces entry, 0x100 now misses.
- Same-cycle update and lookup at same idx -> lookup shows old entry; next cycle shows new; JAL update -> cnt=3 immediately.
- BPU_GSHARE_EN: conditional outcomes T,T,N -> GHR=3'b110 (low bits); lookup of pc 0x100 returns o_pred_idx = 0 ^ 6; async reset asserted mid-sequence clears GHR and all valid bits.
